// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects load data or ALU result, commits it into the
// 32-entry register file, serves two ID read ports plus a debug port, counts commits.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              wwreg,
    input  logic              wm2reg,
    input  logic [DATA_W-1:0] wdataout,
    input  logic [DATA_W-1:0] waluout,
    input  logic [ADDR_W-1:0] wdest,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    output logic [DATA_W-1:0] wdi,
    input  logic [ADDR_W-1:0] dbg_rn,
    output logic [DATA_W-1:0] dbg_q,
    output logic [31:0]       wb_count
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [31:0]       wb_count_q;
    logic [31:0]       wb_count_d;
    logic [DATA_W-1:0] wdi_s;
    logic              we_s;
    logic [DATA_W-1:0] qa_s;
    logic [DATA_W-1:0] qb_s;
    logic [DATA_W-1:0] dbg_s;

    // Entry 0 is never written, and clrn gates commits so a reset cycle drops the pending write.
    assign wdi_s = wm2reg ? wdataout : waluout;
    assign we_s  = wwreg & (wdest != {ADDR_W{1'b0}}) & clrn;

    // Read-port selection: r0 reads zero, a same-cycle commit is optionally forwarded.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] rn,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_en
    );
        logic [DATA_W-1:0] r;
        if (rn == {ADDR_W{1'b0}}) begin
            r = {DATA_W{1'b0}};
        end else if (fwd_en && we_s && (rn == wdest)) begin
            r = wdi_s;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Combinational read ports and retired-write counter next state.
    always_comb begin
        qa_s       = read_sel(rna, regs_q[rna], BYPASS);
        qb_s       = read_sel(rnb, regs_q[rnb], BYPASS);
        dbg_s      = read_sel(dbg_rn, regs_q[dbg_rn], 1'b0);
        wb_count_d = wb_count_q;
        if (we_s) begin
            wb_count_d = wb_count_q + 32'd1;
        end else begin
            wb_count_d = wb_count_q;
        end
    end

    // Register file storage with asynchronous clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            regs_q <= '{default: {DATA_W{1'b0}}};
        end else if (we_s) begin
            regs_q[wdest] <= wdi_s;
        end
    end

    // Commit counter, wraps silently.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wb_count_q <= 32'd0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wdi      = wdi_s;
    assign qa       = qa_s;
    assign qb       = qb_s;
    assign dbg_q    = dbg_s;
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based architectural model; BYPASS=0 copy runs alongside.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        clrn;
    logic        wwreg, wm2reg;
    logic [31:0] wdataout, waluout;
    logic [4:0]  wdest, rna, rnb, dbg_rn;
    logic [31:0] qa, qb, wdi, dbg_q, wb_count;
    logic [31:0] nb_qa, nb_qb, nb_wdi, nb_dbg_q, nb_wb_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [32];
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg),
        .wdataout(wdataout), .waluout(waluout), .wdest(wdest),
        .rna(rna), .rnb(rnb), .qa(qa), .qb(qb), .wdi(wdi),
        .dbg_rn(dbg_rn), .dbg_q(dbg_q), .wb_count(wb_count)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg),
        .wdataout(wdataout), .waluout(waluout), .wdest(wdest),
        .rna(rna), .rnb(rnb), .qa(nb_qa), .qb(nb_qb), .wdi(nb_wdi),
        .dbg_rn(dbg_rn), .dbg_q(nb_dbg_q), .wb_count(nb_wb_count)
    );

    // Architectural read: r0 is zero, a committing write is visible only when forwarding.
    function automatic logic [31:0] exp_rd(input logic [4:0] rn, input bit byp);
        logic [31:0] v;
        logic        w;
        v = wm2reg ? wdataout : waluout;
        w = wwreg && (wdest != 5'd0) && clrn;
        if (rn == 5'd0) return 32'd0;
        if (byp && w && rn == wdest) return v;
        return mdl[rn];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mcnt = 32'd0;
    endtask

    task automatic set_in(input logic we, input logic m2r, input logic [31:0] dout,
                          input logic [31:0] alu, input logic [4:0] dst,
                          input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dr);
        @(negedge clk);
        wwreg = we; wm2reg = m2r; wdataout = dout; waluout = alu;
        wdest = dst; rna = ra; rnb = rb; dbg_rn = dr;
        #1;
    endtask

    // Advance through the rising edge and apply the commit rule to the model.
    task automatic commit();
        logic        w;
        logic [31:0] v;
        w = wwreg && (wdest != 5'd0) && clrn;
        v = wm2reg ? wdataout : waluout;
        @(posedge clk);
        if (w) begin
            mdl[wdest] = v;
            mcnt = mcnt + 32'd1;
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        set_in(1'b1, 1'b0, 32'h0BAD_0BAD, 32'h1357_9BDF, 5'd3, 5'd3, 5'd7, 5'd3);
        model_clear();
        n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL reset_qa: got %h want %h", qa, 32'd0); end
        n_cmp++; if (qb !== 32'd0) begin n_bad++; $display("FAIL reset_qb: got %h want %h", qb, 32'd0); end
        n_cmp++; if (dbg_q !== 32'd0) begin n_bad++; $display("FAIL reset_dbg: got %h want %h", dbg_q, 32'd0); end
        n_cmp++; if (wb_count !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %h want %h", wb_count, 32'd0); end
        n_cmp++; if (wdi !== 32'h1357_9BDF) begin n_bad++; $display("FAIL reset_wdi: got %h want %h", wdi, 32'h1357_9BDF); end
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd0, 5'd3);
        clrn = 1'b1;
        #1;
        n_cmp++; if (dbg_q !== 32'd0) begin n_bad++; $display("FAIL reset_nowrite: got %h want %h", dbg_q, 32'd0); end
    endtask

    task automatic test_alu_commit();
        set_in(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_1234, 5'd5, 5'd0, 5'd0, 5'd5);
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd5);
        n_cmp++; if (dbg_q !== 32'h0000_1234) begin n_bad++; $display("FAIL alu_commit: got %h want %h", dbg_q, 32'h0000_1234); end
        n_cmp++; if (wb_count !== 32'd1) begin n_bad++; $display("FAIL alu_count: got %0d want %0d", wb_count, 1); end
    endtask

    task automatic test_load_bypass();
        set_in(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd9, 5'd9, 5'd9, 5'd9);
        n_cmp++; if (wdi !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_wdi: got %h want %h", wdi, 32'hDEAD_BEEF); end
        n_cmp++; if (qa !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL byp_qa: got %h want %h", qa, 32'hDEAD_BEEF); end
        n_cmp++; if (qb !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL byp_qb: got %h want %h", qb, 32'hDEAD_BEEF); end
        n_cmp++; if (dbg_q !== 32'd0) begin n_bad++; $display("FAIL dbg_nobyp: got %h want %h", dbg_q, 32'd0); end
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd9, 5'd9, 5'd0, 5'd0);
        n_cmp++; if (qa !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_after: got %h want %h", qa, 32'hDEAD_BEEF); end
    endtask

    task automatic test_r0();
        logic [31:0] c0;
        c0 = mcnt;
        set_in(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL r0_before: got %h want %h", qa, 32'd0); end
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL r0_after: got %h want %h", qa, 32'd0); end
        n_cmp++; if (dbg_q !== 32'd0) begin n_bad++; $display("FAIL r0_dbg: got %h want %h", dbg_q, 32'd0); end
        n_cmp++; if (wb_count !== c0) begin n_bad++; $display("FAIL r0_count: got %0d want %0d", wb_count, c0); end
    endtask

    task automatic test_disabled_write();
        logic [31:0] c0;
        c0 = mcnt;
        set_in(1'b0, 1'b0, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 5'd7, 5'd7, 5'd7, 5'd7);
        n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL dis_nobyp: got %h want %h", qa, 32'd0); end
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd0, 5'd7);
        n_cmp++; if (dbg_q !== 32'd0) begin n_bad++; $display("FAIL dis_r7: got %h want %h", dbg_q, 32'd0); end
        n_cmp++; if (wb_count !== c0) begin n_bad++; $display("FAIL dis_count: got %0d want %0d", wb_count, c0); end
    endtask

    task automatic test_no_bypass();
        set_in(1'b1, 1'b0, 32'd0, 32'h0000_0011, 5'd3, 5'd0, 5'd0, 5'd0);
        commit();
        set_in(1'b1, 1'b0, 32'd0, 32'h0000_0055, 5'd3, 5'd3, 5'd3, 5'd3);
        n_cmp++; if (nb_qa !== 32'h0000_0011) begin n_bad++; $display("FAIL nb_old_qa: got %h want %h", nb_qa, 32'h0000_0011); end
        n_cmp++; if (nb_qb !== 32'h0000_0011) begin n_bad++; $display("FAIL nb_old_qb: got %h want %h", nb_qb, 32'h0000_0011); end
        n_cmp++; if (qa !== 32'h0000_0055) begin n_bad++; $display("FAIL byp_new_qa: got %h want %h", qa, 32'h0000_0055); end
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3, 5'd3);
        n_cmp++; if (nb_qa !== 32'h0000_0055) begin n_bad++; $display("FAIL nb_next_qa: got %h want %h", nb_qa, 32'h0000_0055); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b1, k[0], 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), 5'd6, 5'd0, 5'd0, 5'd6);
            commit();
        end
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd6, 5'd0, 5'd6);
        n_cmp++; if (dbg_q !== mdl[6]) begin n_bad++; $display("FAIL b2b_last: got %h want %h", dbg_q, mdl[6]); end
        n_cmp++; if (wb_count !== mcnt) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", wb_count, mcnt); end
    endtask

    task automatic test_random();
        logic [4:0]  d, a, b;
        logic [31:0] e;
        for (int i = 0; i < 300; i++) begin
            d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            a = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
                   d, a, b, 5'($urandom_range(0, 31)));
            e = wm2reg ? wdataout : waluout;
            n_cmp++; if (wdi !== e) begin n_bad++; $display("FAIL rnd_wdi[%0d]: got %h want %h", i, wdi, e); end
            e = exp_rd(rna, 1'b1);
            n_cmp++; if (qa !== e) begin n_bad++; $display("FAIL rnd_qa[%0d]: got %h want %h", i, qa, e); end
            e = exp_rd(rnb, 1'b1);
            n_cmp++; if (qb !== e) begin n_bad++; $display("FAIL rnd_qb[%0d]: got %h want %h", i, qb, e); end
            e = exp_rd(rna, 1'b0);
            n_cmp++; if (nb_qa !== e) begin n_bad++; $display("FAIL rnd_nb_qa[%0d]: got %h want %h", i, nb_qa, e); end
            e = exp_rd(dbg_rn, 1'b0);
            n_cmp++; if (dbg_q !== e) begin n_bad++; $display("FAIL rnd_dbg[%0d]: got %h want %h", i, dbg_q, e); end
            n_cmp++; if (wb_count !== mcnt) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, wb_count, mcnt); end
            commit();
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 1'b0, 32'd0, 32'h0000_0042, 5'd4, 5'd4, 5'd4, 5'd4);
        commit();
        set_in(1'b1, 1'b0, 32'd0, 32'h0000_0099, 5'd4, 5'd4, 5'd4, 5'd4);
        n_cmp++; if (dbg_q !== 32'h0000_0042) begin n_bad++; $display("FAIL ar_pre: got %h want %h", dbg_q, 32'h0000_0042); end
        #2;
        clrn = 1'b0;
        #1;
        model_clear();
        n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL ar_qa: got %h want %h", qa, 32'd0); end
        n_cmp++; if (dbg_q !== 32'd0) begin n_bad++; $display("FAIL ar_dbg: got %h want %h", dbg_q, 32'd0); end
        n_cmp++; if (wb_count !== 32'd0) begin n_bad++; $display("FAIL ar_cnt: got %0d want %0d", wb_count, 0); end
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd4, 5'd4);
        clrn = 1'b1;
        #1;
        n_cmp++; if (qa !== 32'd0) begin n_bad++; $display("FAIL ar_suppressed: got %h want %h", qa, 32'd0); end
        n_cmp++; if (wb_count !== 32'd0) begin n_bad++; $display("FAIL ar_cnt_after: got %0d want %0d", wb_count, 0); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        mcnt = 32'hFFFF_FFFF;
        n_cmp++; if (wb_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want %h", wb_count, 32'hFFFF_FFFF); end
        set_in(1'b1, 1'b0, 32'd0, 32'h0000_0077, 5'd12, 5'd0, 5'd0, 5'd12);
        commit();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd12);
        n_cmp++; if (wb_count !== mcnt) begin n_bad++; $display("FAIL wrap_cnt: got %h want %h", wb_count, mcnt); end
        n_cmp++; if (dbg_q !== 32'h0000_0077) begin n_bad++; $display("FAIL wrap_data: got %h want %h", dbg_q, 32'h0000_0077); end
    endtask

    initial begin
        clrn = 1'b0;
        wwreg = 1'b0; wm2reg = 1'b0; wdataout = 32'd0; waluout = 32'd0;
        wdest = 5'd0; rna = 5'd0; rnb = 5'd0; dbg_rn = 5'd0;
        model_clear();
        test_reset();
        test_alu_commit();
        test_load_bypass();
        test_r0();
        test_disabled_write();
        test_no_bypass();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d compared want completion", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage of the 5-stage pipelined MIPS core; consumes the MEM/WB pipeline-register outputs (wwreg, wm2reg, wdataout, waluout, wdest).
- Selects the write-back value and commits it into the 32x32 general-purpose register file.
- Serves the two ID-stage read ports, with a same-cycle write-to-read bypass.
- Keeps a retired-write counter for performance and debug.

Parameters:
- DATA_W, 32, width of register data and write-back datapath.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- BYPASS, 1, 1 = same-cycle write-back forwarded to read ports; 0 = read returns stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- wwreg  in  1  write-back enable from MEM/WB register.
- wm2reg  in  1  1 = write memory data, 0 = write ALU result.
- wdataout  in  DATA_W  load data from MEM/WB register.
- waluout  in  DATA_W  ALU result from MEM/WB register.
- wdest  in  ADDR_W  destination register index.
- rna  in  ADDR_W  read port A index (rs).
- rnb  in  ADDR_W  read port B index (rt).
- qa  out  DATA_W  read port A data.
- qb  out  DATA_W  read port B data.
- wdi  out  DATA_W  selected write-back value, exported for EX-stage forwarding.
- dbg_rn  in  ADDR_W  debug read index.
- dbg_q  out  DATA_W  debug read data; no bypass.
- wb_count  out  32  number of committed register writes since reset.

Behaviour:
- Reset: clk/clrn as already decided; reset clrn, asynchronous, active-low; clock clk. While clrn = 0, regs[1..31] and wb_count clear to 0 immediately and no write occurs.
- Outputs during reset: qa, qb and dbg_q read 0. wdi stays combinational.
- wdi: wdi = wm2reg ? wdataout : waluout, purely combinational at all times.
- Write enable: we = wwreg & (wdest != 0) & clrn.
- Commit: on rising clk with we = 1, regs[wdest] <= wdi. Latency from MEM/WB register update to architectural commit is one cycle.
- Register 0: hardwired to zero. Never written, with no side effects: a write to r0 does not increment wb_count. Any read of index 0 returns 0 on all ports, bypass included.
- Read ports: combinational.
  - qa = 0 if rna = 0.
  - Else wdi if BYPASS = 1 and we = 1 and rna = wdest.
  - Else regs[rna].
  - qb is identical using rnb.
- Simultaneous reads: rna = rnb = wdest with we = 1 gives both ports wdi.
- Bypass disabled: with BYPASS = 0, a same-cycle read of wdest returns the old value; the new value is visible from the next cycle.
- dbg_q: regs[dbg_rn], or 0 for index 0. Never bypassed.
- wb_count: increments by 1 on each rising edge with we = 1. Wraps 0xFFFFFFFF -> 0 with no flag.
- Back-to-back writes to the same register commit in order; the last write wins.
- Reset mid-operation: clrn falling in the same cycle as a pending write suppresses that write, and the register reads 0 afterwards.
- X-safety: when wwreg = 0, the values on wdest, wdataout and waluout have no effect on state.

Test Plan:
- Reset then ALU commit: reset; then wwreg=1, wm2reg=0, waluout=0x0000_1234, wdest=5 for 1 cycle -> after edge, dbg_rn=5 gives dbg_q=0x0000_1234 and wb_count=1.
- Load select and bypass: wwreg=1, wm2reg=1, wdataout=0xDEAD_BEEF, waluout=0x1111_1111, wdest=9, rna=9, rnb=9 -> in the same cycle wdi=qa=qb=0xDEAD_BEEF; after the edge, with wwreg=0, qa=0xDEAD_BEEF.
- r0 protection: wwreg=1, wdest=0, waluout=0xFFFF_FFFF, rna=0 -> qa=0 both before and after the edge, dbg_q(0)=0, wb_count unchanged.
- Disabled write and BYPASS=0: wwreg=0, wdest=7, waluout=0xAAAA_AAAA -> r7 stays 0, wb_count unchanged. With BYPASS=0, writing 0x55 to r3 while rna=3 -> qa = old value that cycle, 0x55 the next cycle.
- Async reset mid-stream: write 0x42 to r4, then assert clrn low between clock edges -> qa(r4)=0 and wb_count=0 immediately, without waiting for a clock edge; the write pending at the reset edge is not committed.
- Counter wrap: force 2^32 committed writes (or preload via a bench hierarchical deposit to 0xFFFF_FFFF) and do one more commit -> wb_count=0.
